// File: rtl/csea16_registered_if.sv
// Operand/result bundle for the registered 16-bit carry-select adder.
// master drives A/B/Cin and reads Sum/Cout; slave is the adder side.
interface csea16_registered_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] Sum;
  logic             Cout;

  modport master (
    output A, B, Cin,
    input  Sum, Cout
  );

  modport slave (
    input  A, B, Cin,
    output Sum, Cout
  );
endinterface

// File: rtl/csea16_registered.sv
// Registered 16-bit carry-select adder: {Cout,Sum} = A+B+Cin, 1-cycle latency.
// Ports: Clk, Rst_n (async active-low), bus (slave: A,B,Cin in; Sum,Cout out).
module csea16_registered #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic               Clk,
  input  logic               Rst_n,
  csea16_registered_if.slave bus
);

  if (WIDTH != 16 || BLK != 4) begin : g_bad_cfg
    $error("csea16_registered supports only WIDTH=16, BLK=4");
  end

  function automatic logic [4:0] rca4(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       ci
  );
    logic [4:0] r;
    logic       cc;
    r  = '0;
    cc = ci;
    for (int i = 0; i < 4; i++) begin
      r[i] = a[i] ^ b[i] ^ cc;
      cc   = (a[i] & b[i]) | (cc & (a[i] ^ b[i]));
    end
    r[4] = cc;
    return r;
  endfunction

  logic [4:0] b0_r;
  logic [4:0] b1_r0, b1_r1;
  logic [4:0] b2_r0, b2_r1;
  logic [4:0] b3_r0, b3_r1;
  logic       c4, c8, c12, c16;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;

  // Block 0 ripples from Cin; upper blocks precompute both carry-in cases.
  assign b0_r  = rca4(bus.A[3:0],   bus.B[3:0],   bus.Cin);
  assign b1_r0 = rca4(bus.A[7:4],   bus.B[7:4],   1'b0);
  assign b1_r1 = rca4(bus.A[7:4],   bus.B[7:4],   1'b1);
  assign b2_r0 = rca4(bus.A[11:8],  bus.B[11:8],  1'b0);
  assign b2_r1 = rca4(bus.A[11:8],  bus.B[11:8],  1'b1);
  assign b3_r0 = rca4(bus.A[15:12], bus.B[15:12], 1'b0);
  assign b3_r1 = rca4(bus.A[15:12], bus.B[15:12], 1'b1);

  // Select chain: the only serial path after block 0 is three 2:1 muxes.
  assign c4  = b0_r[4];
  assign c8  = c4  ? b1_r1[4] : b1_r0[4];
  assign c12 = c8  ? b2_r1[4] : b2_r0[4];
  assign c16 = c12 ? b3_r1[4] : b3_r0[4];

  assign sum_d[3:0]   = b0_r[3:0];
  assign sum_d[7:4]   = c4  ? b1_r1[3:0] : b1_r0[3:0];
  assign sum_d[11:8]  = c8  ? b2_r1[3:0] : b2_r0[3:0];
  assign sum_d[15:12] = c12 ? b3_r1[3:0] : b3_r0[3:0];
  assign cout_d       = c16;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;

endmodule

// File: tb/tb_csea16_registered.sv
// Scoreboard bench for csea16_registered: directed vectors, async reset,
// random vectors vs A+B+Cin golden model.
module tb_csea16_registered;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic vld   = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  csea16_registered_if ifc ();

  csea16_registered dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (ifc)
  );

  task automatic chk(input string n, input logic [16:0] act,
                     input logic [16:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic [16:0] e);
    @(negedge clk);
    ifc.A   = a;
    ifc.B   = b;
    ifc.Cin = c;
    vld     = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vld     = 1'b0;
      ifc.A   = 16'($urandom);
      ifc.B   = 16'($urandom);
      ifc.Cin = 1'($urandom);
    end
  endtask

  // Monitor: a vector captured on this edge must appear right after it.
  always @(posedge clk) begin
    logic        p;
    logic [16:0] e;
    p = vld && rst_n;
    #1;
    if (p) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 17'h1, 17'h0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_result", {ifc.Cout, ifc.Sum}, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [16:0] e;
  } vec_t;

  vec_t dir[9];

  initial begin
    logic [15:0] ra, rb;
    logic        rc;

    dir[0] = '{16'h1234, 16'h4321, 1'b0, 17'h05555};
    dir[1] = '{16'hFFFF, 16'h0000, 1'b1, 17'h10000};
    dir[2] = '{16'h000F, 16'h0001, 1'b0, 17'h00010};
    dir[3] = '{16'h00FF, 16'h0F01, 1'b0, 17'h01000};
    dir[4] = '{16'h8000, 16'h8000, 1'b0, 17'h10000};
    dir[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};
    dir[6] = '{16'h0001, 16'h0001, 1'b0, 17'h00002};
    dir[7] = '{16'h7FFF, 16'h0001, 1'b0, 17'h08000};
    dir[8] = '{16'hABCD, 16'h1234, 1'b1, 17'h0BE02};

    ifc.A   = 16'h0;
    ifc.B   = 16'h0;
    ifc.Cin = 1'b0;
    #1;
    chk("reset_t0", {ifc.Cout, ifc.Sum}, 17'h0);

    for (int i = 0; i < 4; i++) begin
      idle(1);
      @(posedge clk);
      #1;
      chk("reset_hold", {ifc.Cout, ifc.Sum}, 17'h0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      issue(dir[i].a, dir[i].b, dir[i].c, dir[i].e);
    end

    @(posedge clk);
    #2;
    chk("pre_async", {ifc.Cout, ifc.Sum}, 17'h0BE02);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {ifc.Cout, ifc.Sum}, 17'h0);
    idle(2);
    #1;
    chk("rst_discard", {ifc.Cout, ifc.Sum}, 17'h0);
    rst_n = 1'b1;

    issue(16'h0F0F, 16'h00F1, 1'b0, 17'h01000);
    issue(16'hFFF0, 16'h0010, 1'b0, 17'h10000);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      issue(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {16'h0, rc});
    end

    idle(3);
    chk("sb_drained", 17'(exp_q.size()), 17'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
